// File: rtl/comar_pkg.sv
// Shared constants, FSM state type and sizing helper for the COMAR mask source.
package comar_pkg;
  localparam int LFSR_W = 64;
  localparam int SEED_W = 32;
  localparam int TAP0   = 63;
  localparam int TAP1   = 62;
  localparam int TAP2   = 60;
  localparam int TAP3   = 59;

  typedef enum logic [1:0] {UNSEEDED, SEED1, WARMUP, RUN} state_e;

  function automatic int out_w(input int n);
    return 7 * n;
  endfunction
endpackage

// File: rtl/comar_mask_source_if.sv
// Seed handshake and mask delivery bus between the mask source and the datapath controller.
interface comar_mask_source_if #(parameter int NUM_GADGETS = 4);
  import comar_pkg::*;

  logic                     seed_valid;
  logic                     seed_ready;
  logic [SEED_W-1:0]        seed_data;
  logic                     r_next;
  logic                     r_valid;
  logic [6*NUM_GADGETS-1:0] r_out;
  logic [NUM_GADGETS-1:0]   common_out;

  modport master (input seed_valid, seed_data, r_next,
                  output seed_ready, r_valid, r_out, common_out);
  modport slave  (output seed_valid, seed_data, r_next,
                  input seed_ready, r_valid, r_out, common_out);
endinterface

// File: rtl/comar_lfsr_step.sv
// Combinational N-shift unroll of the x^64+x^63+x^61+x^60+1 Fibonacci LFSR; new_bits[0] is the oldest.
module comar_lfsr_step import comar_pkg::*; #(
  parameter int N = 1
) (
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state,
  output logic [N-1:0]      new_bits
);
  logic [N:0][LFSR_W-1:0] chain;

  assign chain[0] = state;

  for (genvar i = 0; i < N; i++) begin : g_shift
    assign new_bits[i]  = chain[i][TAP0] ^ chain[i][TAP1] ^ chain[i][TAP2] ^ chain[i][TAP3];
    assign chain[i+1]   = {chain[i][LFSR_W-2:0], new_bits[i]};
  end

  assign next_state = chain[N];
endmodule

// File: rtl/comar_mask_source.sv
// Fresh-randomness source for 2-share COMAR AND gadgets: seeded LFSR, warm-up, one word per r_next.
// Optional COMAR_MASK_CNT_EN adds a saturating mask_count output of r_next steps taken in RUN.
module comar_mask_source import comar_pkg::*; #(
  parameter int NUM_GADGETS   = 4,
  parameter int WARMUP_CYCLES = 128
) (
  input logic clk,
  input logic rst,
  comar_mask_source_if.master bus
`ifdef COMAR_MASK_CNT_EN
  , output logic [31:0] mask_count
`endif
);
  localparam int OUT_W = out_w(NUM_GADGETS);
  localparam int R_W   = 6 * NUM_GADGETS;

  state_e              state, state_nx;
  logic [LFSR_W-1:0]   lfsr, lfsr_nx, seed_full, step_in, step_out;
  logic [OUT_W-1:0]    word;
  logic [7:0]          warm_cnt, warm_cnt_nx;
  logic                seed_hs, load, advance;
  logic [R_W-1:0]      r_q;
  logic [NUM_GADGETS-1:0] c_q;

  assign bus.seed_ready = (state != WARMUP);
  assign bus.r_valid    = (state == RUN);
  assign bus.r_out      = r_q;
  assign bus.common_out = c_q;

  assign seed_hs   = bus.seed_valid && bus.seed_ready;
  assign seed_full = {bus.seed_data, lfsr[SEED_W-1:0]};
  // In SEED1 the step unit sees the just-completed seed so a zero-warm-up load needs no extra cycle.
  assign step_in   = (state != SEED1)   ? lfsr :
                     (seed_full == '0)  ? LFSR_W'(1) : seed_full;

  // Warm-up and advance both move the LFSR by a full OUT_W-shift step per cycle.
  comar_lfsr_step #(.N(OUT_W)) u_step (
    .state      (step_in),
    .next_state (step_out),
    .new_bits   (word)
  );

  always_comb begin
    state_nx    = state;
    lfsr_nx     = lfsr;
    warm_cnt_nx = warm_cnt;
    load        = 1'b0;
    advance     = 1'b0;
    case (state)
      UNSEEDED: if (seed_hs) begin
        lfsr_nx  = {lfsr[LFSR_W-1:SEED_W], bus.seed_data};
        state_nx = SEED1;
      end
      SEED1: if (seed_hs) begin
        warm_cnt_nx = '0;
        if (WARMUP_CYCLES == 0) begin
          lfsr_nx  = step_out;
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          lfsr_nx  = step_in;
          state_nx = WARMUP;
        end
      end
      WARMUP: begin
        lfsr_nx = step_out;
        if (warm_cnt == 8'(WARMUP_CYCLES)) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          warm_cnt_nx = warm_cnt + 8'd1;
        end
      end
      RUN: if (seed_hs) begin
        // Reseed wins over a same-cycle r_next; outputs go stale, not advanced.
        lfsr_nx  = {lfsr[LFSR_W-1:SEED_W], bus.seed_data};
        state_nx = SEED1;
      end else if (bus.r_next) begin
        lfsr_nx = step_out;
        load    = 1'b1;
        advance = 1'b1;
      end
      default: state_nx = UNSEEDED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNSEEDED;
      lfsr     <= LFSR_W'(1);
      warm_cnt <= '0;
      r_q      <= '0;
      c_q      <= '0;
    end else begin
      state    <= state_nx;
      lfsr     <= lfsr_nx;
      warm_cnt <= warm_cnt_nx;
      if (load) begin
        r_q <= word[R_W-1:0];
        c_q <= word[OUT_W-1:R_W];
      end
    end
  end

`ifdef COMAR_MASK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (state == SEED1 && seed_hs))
      mask_count <= '0;
    else if (advance && mask_count != 32'hFFFF_FFFF)
      mask_count <= mask_count + 32'd1;
  end
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif
endmodule
